// File: rtl/weight_stream_reader.sv
// weight_stream_reader: streams DEPTH BRAM words in address order through a 2-entry valid/ready buffer
// Optional CHECKSUM output is enabled by defining WSTREAM_CHECKSUM_EN.
module weight_stream_reader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 28
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_di_o,
   input  logic [DATA_W-1:0] mem_do_i,
   output logic [DATA_W-1:0] w_data_o,
   output logic [ADDR_W-1:0] w_idx_o,
   output logic              w_last_o,
   output logic              w_valid_o,
`ifdef WSTREAM_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum_o,
`endif
   input  logic              w_ready_i
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, addr_q, addr_d, idx0_q, idx0_d, idx1_q, idx1_d;
   logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
   logic [1:0]        occ_q, occ_d, wslot;
   logic              en_q, en_d, done_q, done_d, push, pop, issue, accept;
`ifdef WSTREAM_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif
   // Next state: FSM, read issue gated so the capture can never overflow the buffer, and buffer shift
   always_comb begin
      push     = en_q;
      pop      = (occ_q != 2'd0) && w_ready_i;
      occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
      wslot    = occ_q - {1'b0, pop};
      accept   = (state_q == IDLE) && start_i;
      issue    = (state_q == FETCH) && (occ_d <= 2'd1);
      state_d  = state_q;
      rd_ptr_d = accept ? '0 : issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
      addr_d   = issue ? rd_ptr_q : addr_q;
      en_d     = issue;
      done_d   = 1'b0;
      dat0_d   = pop ? dat1_q : dat0_q;
      idx0_d   = pop ? idx1_q : idx0_q;
      dat1_d   = dat1_q;
      idx1_d   = idx1_q;
      if (accept) state_d = FETCH;
      if (issue && rd_ptr_q == LAST) state_d = DRAIN;
      if (state_q == DRAIN && pop && idx0_q == LAST) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end
      if (push && wslot == 2'd0) begin
         dat0_d = mem_do_i;
         idx0_d = addr_q;
      end else if (push) begin
         dat1_d = mem_do_i;
         idx1_d = addr_q;
      end
`ifdef WSTREAM_CHECKSUM_EN
      sum_d = accept ? '0 : pop ? sum_q + dat0_q : sum_q;
`endif
   end
   // State registers with synchronous active-low reset; reset also drops any in-flight read
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         addr_q   <= '0;
         en_q     <= 1'b0;
         done_q   <= 1'b0;
         occ_q    <= '0;
         dat0_q   <= '0;
         dat1_q   <= '0;
         idx0_q   <= '0;
         idx1_q   <= '0;
`ifdef WSTREAM_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         addr_q   <= addr_d;
         en_q     <= en_d;
         done_q   <= done_d;
         occ_q    <= occ_d;
         dat0_q   <= dat0_d;
         dat1_q   <= dat1_d;
         idx0_q   <= idx0_d;
         idx1_q   <= idx1_d;
`ifdef WSTREAM_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end
   assign busy_o     = state_q != IDLE;
   assign done_o     = done_q;
   assign mem_en_o   = en_q;
   assign mem_we_o   = 1'b0;
   assign mem_addr_o = addr_q;
   assign mem_di_o   = '0;
   assign w_valid_o  = occ_q != 2'd0;
   assign w_data_o   = dat0_q;
   assign w_idx_o    = idx0_q;
   assign w_last_o   = w_valid_o && idx0_q == LAST;
`ifdef WSTREAM_CHECKSUM_EN
   assign checksum_o = sum_q;
`endif
endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader: directed + randomized checks of weight_stream_reader against a scoreboard model
module tb_weight_stream_reader;
   localparam int DEPTH = 28;
   logic        clk, rst_n, start, busy, done, mem_en, mem_we, w_last, w_valid, w_ready;
   logic [4:0]  mem_addr, w_idx;
   logic [15:0] mem_di, mem_do, w_data;
   logic [15:0] mem [32];
`ifdef WSTREAM_CHECKSUM_EN
   logic [15:0] checksum;
`endif
   int          vectors = 0, errs = 0, edges = 0, start_edge = 0, exp_next = 0, issued = 0, xfers = 0, dn = 0;
   logic        in_vec = 0;
   logic [15:0] sum_m = 0;

   weight_stream_reader dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_di_o(mem_di),
      .mem_do_i(mem_do), .w_data_o(w_data), .w_idx_o(w_idx), .w_last_o(w_last),
      .w_valid_o(w_valid),
`ifdef WSTREAM_CHECKSUM_EN
      .checksum_o(checksum),
`endif
      .w_ready_i(w_ready)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   // BRAM model: samples EN/ADDR on negedge, data ready by the next posedge
   always @(negedge clk) if (mem_en === 1'b1) mem_do <= mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample pre-edge handshake, advance, then update the scoreboard and compare
   task automatic tick();
      logic ok, xf, stall, st, dexp;
      logic [15:0] d;
      logic [4:0] ix;
      logic l;
      ok    = rst_n;
      xf    = ok && (w_valid === 1'b1) && (w_ready === 1'b1);
      stall = ok && (w_valid === 1'b1) && (w_ready === 1'b0);
      st    = ok && start && !in_vec;
      d = w_data; ix = w_idx; l = w_last;
      @(posedge clk); #1;
      edges++;
      dexp = 1'b0;
      if (!ok) begin
         in_vec = 0; exp_next = 0; issued = 0; xfers = 0; sum_m = 0;
      end else begin
         if (st) begin
            in_vec = 1; exp_next = 0; issued = 0; xfers = 0; sum_m = 0; start_edge = edges;
         end
         if (xf) begin
            chk("w_idx", ix, exp_next);
            chk("w_data", d, mem[exp_next & 31]);
            chk("w_last", l, exp_next == DEPTH - 1);
            dexp = exp_next == DEPTH - 1;
            sum_m += d;
            xfers++;
            exp_next++;
         end
`ifdef WSTREAM_CHECKSUM_EN
         if (dexp) chk("checksum", checksum, sum_m);
`endif
         if (dexp) in_vec = 0;
         if (mem_en === 1'b1) begin
            chk("mem_addr", mem_addr, issued);
            issued++;
         end
         chk("outstanding", (issued - xfers) <= 2, 1);
         chk("issued_max", issued <= DEPTH, 1);
         if (stall) chk("hold", {w_valid, w_idx, w_data}, {1'b1, ix, d});
      end
      chk("done", done, dexp);
      chk("busy", busy, in_vec);
      chk("mem_we", {mem_we, mem_di}, 0);
   endtask

   task automatic chk_reset();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_valid", w_valid, 0);
      chk("rst_last", w_last, 0);
      chk("rst_data", w_data, 0);
      chk("rst_idx", w_idx, 0);
`ifdef WSTREAM_CHECKSUM_EN
      chk("rst_checksum", checksum, 0);
`endif
   endtask

   // Run until DONE with a ready pattern: 0 always high, 1 toggling, 2 random
   task automatic run_vec(input int mode, input int budget, output int dn_edge);
      dn_edge = -1;
      for (int n = 0; n < budget && dn_edge < 0; n++) begin
         w_ready = mode == 0 ? 1'b1 : mode == 1 ? ~w_ready : 1'($urandom_range(0, 1));
         tick();
         if (done === 1'b1) dn_edge = edges;
      end
      if (dn_edge < 0) chk("timeout", 0, 1);
   endtask

   task automatic pulse_start();
      start = 1;
      tick();
      start = 0;
   endtask

   initial begin
      rst_n = 0; start = 0; w_ready = 1;
      for (int k = 0; k < 32; k++) mem[k] = 16'(k + 1);
      tick(); tick();
      chk_reset();
      rst_n = 1;
      tick();
      // Test 1: full-rate stream, latency, DONE timing
      pulse_start();
      chk("start_valid", w_valid, 0);
      tick();
      chk("first_en", mem_en, 1);
      chk("first_valid", w_valid, 0);
      tick();
      chk("first_word", {w_valid, w_data, w_idx}, {1'b1, 16'd1, 5'd0});
      run_vec(0, 100, dn);
      chk("done_edge", dn - start_edge, 30);
      chk("xfer_count", xfers, DEPTH);
`ifdef WSTREAM_CHECKSUM_EN
      chk("checksum_406", checksum, 16'h0196);
`endif
      tick();
      // Test 2: 5-cycle stall after first word valid
      pulse_start();
      for (int n = 0; n < 10 && w_valid !== 1'b1; n++) tick();
      chk("stall_valid", w_valid, 1);
      w_ready = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("stall_data", w_data, 1);
         if (n >= 2) chk("stall_no_en", mem_en, 0);
      end
      run_vec(0, 100, dn);
      chk("stall_xfers", xfers, DEPTH);
      // Test 3: toggling ready
      pulse_start();
      run_vec(1, 200, dn);
      chk("toggle_xfers", xfers, DEPTH);
      // Test 4: START ignored while busy, back-to-back START on DONE cycle
      for (int k = 0; k < 32; k++) mem[k] = 16'($urandom);
      pulse_start();
      for (int n = 0; n < 200 && exp_next < 10; n++) begin
         w_ready = 1'($urandom_range(0, 1));
         tick();
      end
      chk("reach_w10", exp_next >= 10, 1);
      pulse_start();
      run_vec(2, 300, dn);
      chk("single_vec", xfers, DEPTH);
      pulse_start();
      chk("b2b_busy", busy, 1);
      chk("b2b_edge", edges - start_edge, 0);
      run_vec(2, 300, dn);
      // Test 5: reset mid-stream
      pulse_start();
      for (int n = 0; n < 200 && exp_next < 15; n++) begin
         w_ready = 1'($urandom_range(0, 1));
         tick();
      end
      chk("reach_w15", exp_next >= 15, 1);
      rst_n = 0;
      tick();
      chk_reset();
      rst_n = 1;
      for (int n = 0; n < 4; n++) tick();
      chk("idle_after_rst", {busy, w_valid, mem_en}, 0);
      pulse_start();
      run_vec(2, 300, dn);
      chk("post_rst_xfers", xfers, DEPTH);
      // Randomized vectors
      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < 32; k++) mem[k] = 16'($urandom);
         for (int n = 0; n < int'($urandom_range(0, 3)); n++) tick();
         pulse_start();
         run_vec(2, 300, dn);
         chk("rand_xfers", xfers, DEPTH);
      end
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
